// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the oversampled SPI slave.
package spi_slave_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill counter; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module sync_fifo
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; validity comes from the count, and rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// Full-duplex SPI slave, all pins oversampled in clk, with RX/TX FIFOs.
// Define SPI_SLAVE_LSB_FIRST_EN to shift both lines LSB first.
module spi_slave_fifo
    import spi_slave_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter int              RX_DEPTH = 8,
    parameter int              TX_DEPTH = 8,
    parameter int              CPOL     = 0,
    parameter int              CPHA     = 0,
    parameter logic [WIDTH-1:0] TX_IDLE = '1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_rd,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic             tx_full,
    output logic             rx_ovf,
    output logic             tx_udf,
    input  logic             err_clr,
    output logic             busy,
    input  logic             ss,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe
);

    localparam int         CNT_W       = $clog2(WIDTH);
    localparam logic [1:0] MODE        = {1'(CPOL), 1'(CPHA)};
    localparam logic       IDLE_LVL    = (MODE == MODE2) || (MODE == MODE3);
    localparam logic       SAMPLE_LEAD = (MODE == MODE0) || (MODE == MODE2);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   sclk_sync;
    logic                   ss_s, ss_prev, mosi_s;
    logic                   sclk_edge, lead_edge, sample_edge, shift_edge;

    state_t           state;
    logic [WIDTH-1:0] rx_sh, tx_sh, rx_next, tx_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             push_q, skip_shift, udf_pend;
    logic             active, tx_load, word_done;
    logic [WIDTH-1:0] tx_head, load_word;
    logic             rx_full, rx_empty, tx_empty;

    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic                      unused_counts;

    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_edge   = sclk_sync[SYNC_STAGES] != sclk_sync[SYNC_STAGES-1];
    assign lead_edge   = sclk_edge && (sclk_sync[SYNC_STAGES] == IDLE_LVL);
    assign sample_edge = sclk_edge && (lead_edge == SAMPLE_LEAD);
    assign shift_edge  = sclk_edge && !sample_edge;

    assign active    = (state == SHIFT) && !ss_s;
    assign tx_load   = ((state == IDLE) && ss_prev && !ss_s) || (active && push_q);
    assign load_word = tx_empty ? TX_IDLE : tx_head;
    assign word_done = active && sample_edge && (bit_cnt == CNT_W'(WIDTH - 1));

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next = {mosi_s, rx_sh[WIDTH-1:1]};
    assign tx_next = {1'b0, tx_sh[WIDTH-1:1]};
    assign miso    = tx_sh[0];
`else
    assign rx_next = {rx_sh[WIDTH-2:0], mosi_s};
    assign tx_next = {tx_sh[WIDTH-2:0], 1'b0};
    assign miso    = tx_sh[WIDTH-1];
`endif

    assign busy          = (state == SHIFT);
    assign miso_oe       = busy;
    assign rx_valid      = !rx_empty;
    assign unused_counts = ^{rx_count, tx_count};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // ss held "asserted" through reset so a frame already in flight is ignored until ss cycles
            ss_sync    <= '0;
            ss_prev    <= 1'b0;
            mosi_sync  <= '0;
            sclk_sync  <= {(SYNC_STAGES + 1){IDLE_LVL}};
            state      <= IDLE;
            rx_sh      <= '0;
            tx_sh      <= '0;
            bit_cnt    <= '0;
            push_q     <= 1'b0;
            skip_shift <= 1'b0;
            udf_pend   <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], sclk};
            ss_prev   <= ss_s;
            push_q    <= word_done;
            unique case (state)
                IDLE: begin
                    if (tx_load) begin
                        state      <= SHIFT;
                        tx_sh      <= load_word;
                        udf_pend   <= tx_empty;
                        skip_shift <= !SAMPLE_LEAD;
                        bit_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (ss_s) begin
                        state      <= IDLE;
                        tx_sh      <= '0;
                        bit_cnt    <= '0;
                        udf_pend   <= 1'b0;
                        skip_shift <= 1'b0;
                    end else begin
                        // A fresh word already shows its first bit, so the next shift edge is swallowed
                        if (tx_load) begin
                            tx_sh      <= load_word;
                            udf_pend   <= tx_empty;
                            skip_shift <= 1'b1;
                        end else if (shift_edge) begin
                            if (skip_shift) skip_shift <= 1'b0;
                            else            tx_sh      <= tx_next;
                        end
                        if (sample_edge) begin
                            rx_sh    <= rx_next;
                            bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
                            udf_pend <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Underflow counts once the idle word is actually clocked out, not when it is merely loaded
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_ovf <= 1'b0;
            tx_udf <= 1'b0;
        end else begin
            if (push_q && rx_full && !rx_rd)       rx_ovf <= 1'b1;
            else if (err_clr)                      rx_ovf <= 1'b0;
            if (active && sample_edge && udf_pend) tx_udf <= 1'b1;
            else if (err_clr)                      tx_udf <= 1'b0;
        end
    end

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_q),
        .wdata  (rx_sh),
        .pop    (rx_rd),
        .rdata  (rx_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_wr && !tx_full),
        .wdata  (tx_data),
        .pop    (tx_load),
        .rdata  (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench: an 8-bit mode-0 slave (a) and a 16-bit mode-3 slave (b) driven by a bit-banged master.
module tb_spi_slave_fifo;

    localparam int H = 8;  // clk cycles per sclk half period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, sclk, mosi, ss_a, ss_b;

    logic [7:0]  rx_data_a, tx_data_a;
    logic        rx_valid_a, rx_rd_a, tx_wr_a, tx_full_a, rx_ovf_a, tx_udf_a;
    logic        err_clr_a, busy_a, miso_a, miso_oe_a;

    logic [15:0] rx_data_b, tx_data_b;
    logic        rx_valid_b, rx_rd_b, tx_wr_b, tx_full_b, rx_ovf_b, tx_udf_b;
    logic        err_clr_b, busy_b, miso_b, miso_oe_b;

    int n_vec = 0;
    int n_bad = 0;

    spi_slave_fifo #(.WIDTH(8), .RX_DEPTH(4), .TX_DEPTH(4), .CPOL(0), .CPHA(0)) dut_a (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_rd(rx_rd_a),
        .tx_data(tx_data_a), .tx_wr(tx_wr_a), .tx_full(tx_full_a),
        .rx_ovf(rx_ovf_a), .tx_udf(tx_udf_a), .err_clr(err_clr_a), .busy(busy_a),
        .ss(ss_a), .sclk(sclk), .mosi(mosi), .miso(miso_a), .miso_oe(miso_oe_a)
    );

    spi_slave_fifo #(.WIDTH(16), .RX_DEPTH(4), .TX_DEPTH(2), .CPOL(1), .CPHA(1)) dut_b (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_rd(rx_rd_b),
        .tx_data(tx_data_b), .tx_wr(tx_wr_b), .tx_full(tx_full_b),
        .rx_ovf(rx_ovf_b), .tx_udf(tx_udf_b), .err_clr(err_clr_b), .busy(busy_b),
        .ss(ss_b), .sclk(sclk), .mosi(mosi), .miso(miso_b), .miso_oe(miso_oe_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ss(input bit b_sel, input logic v);
        if (b_sel) ss_b = v;
        else       ss_a = v;
        clks(6);
    endtask

    // Master transfer of nbits (MSB first); rd_on_push pulses rx_rd_a on the cycle the last word is pushed.
    task automatic xfer(input bit b_sel, input int nbits, input logic [31:0] mo,
                        input bit rd_on_push, output logic [31:0] mi);
        logic cpol;
        int   w;
        cpol = b_sel;
        w    = b_sel ? 16 : 8;
        mi   = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!b_sel) begin
                mosi = mo[w-1-i];
                clks(H);
                mi   = {mi[30:0], miso_a};
                sclk = ~cpol;
                for (int j = 1; j <= H; j++) begin
                    @(negedge clk);
                    if (rd_on_push && i == nbits - 1) rx_rd_a = (j == 3);
                end
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mo[w-1-i];
                clks(H);
                mi   = {mi[30:0], miso_b};
                sclk = cpol;
                clks(H);
            end
        end
        clks(H);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        check(tag, rx_data_a, exp);
        rx_rd_a = 1'b1;
        @(negedge clk);
        rx_rd_a = 1'b0;
    endtask

    task automatic pop_b(input string tag, input logic [15:0] exp);
        check(tag, rx_data_b, exp);
        rx_rd_b = 1'b1;
        @(negedge clk);
        rx_rd_b = 1'b0;
    endtask

    task automatic push_tx(input bit b_sel, input logic [15:0] d);
        if (b_sel) begin tx_data_b = d;      tx_wr_b = 1'b1; end
        else       begin tx_data_a = d[7:0]; tx_wr_a = 1'b1; end
        @(negedge clk);
        tx_wr_a = 1'b0;
        tx_wr_b = 1'b0;
    endtask

    task automatic pulse_err_clr(input bit b_sel);
        if (b_sel) err_clr_b = 1'b1;
        else       err_clr_a = 1'b1;
        @(negedge clk);
        err_clr_a = 1'b0;
        err_clr_b = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [15:0] words_b [3];
        logic [7:0]  words_a [5];
        words_b = '{16'h1234, 16'hBEEF, 16'h0001};

        resetn = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_a = 1'b1; ss_b = 1'b1;
        rx_rd_a = 1'b0; tx_wr_a = 1'b0; err_clr_a = 1'b0; tx_data_a = '0;
        rx_rd_b = 1'b0; tx_wr_b = 1'b0; err_clr_b = 1'b0; tx_data_b = '0;
        clks(3);
        resetn = 1'b1;
        clks(2);

        // reset state
        check("rst_rx_data",  rx_data_a,  0);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_tx_full",  tx_full_a,  0);
        check("rst_rx_ovf",   rx_ovf_a,   0);
        check("rst_tx_udf",   tx_udf_a,   0);
        check("rst_busy",     busy_a,     0);
        check("rst_miso",     miso_a,     0);
        check("rst_miso_oe",  miso_oe_a,  0);

        // 1: mode 0 single byte, preloaded reply
        push_tx(0, 16'h003C);
        check("t1_tx_full", tx_full_a, 0);
        set_ss(0, 1'b0);
        check("t1_busy", busy_a, 1);
        check("t1_miso_oe", miso_oe_a, 1);
        xfer(0, 8, 32'hA5, 0, got);
        check("t1_master_rx", got, 32'h3C);
        set_ss(0, 1'b1);
        check("t1_rx_valid", rx_valid_a, 1);
        check("t1_tx_udf", tx_udf_a, 0);
        check("t1_busy_end", busy_a, 0);
        pop_a("t1_rx_data", 8'hA5);
        check("t1_rx_empty", rx_valid_a, 0);

        // 2: mode 3, three back-to-back 16-bit words, empty TX FIFO
        sclk = 1'b1;
        clks(4);
        set_ss(1, 1'b0);
        check("t2_miso_oe", miso_oe_b, 1);
        for (int k = 0; k < 3; k++) begin
            xfer(1, 16, {16'h0, words_b[k]}, 0, got);
            check($sformatf("t2_master_rx%0d", k), got, 32'hFFFF);
        end
        set_ss(1, 1'b1);
        check("t2_tx_udf", tx_udf_b, 1);
        check("t2_rx_ovf", rx_ovf_b, 0);
        for (int k = 0; k < 3; k++) pop_b($sformatf("t2_rx_word%0d", k), words_b[k]);
        check("t2_rx_empty", rx_valid_b, 0);

        // 2b: TX FIFO full boundary, third push ignored
        push_tx(1, 16'hAAAA);
        push_tx(1, 16'hBBBB);
        check("t2b_tx_full", tx_full_b, 1);
        push_tx(1, 16'hCCCC);
        pulse_err_clr(1);
        check("t2b_udf_clr", tx_udf_b, 0);
        set_ss(1, 1'b0);
        xfer(1, 16, 32'h0, 0, got);
        check("t2b_rx0", got, 32'hAAAA);
        check("t2b_not_full", tx_full_b, 0);
        xfer(1, 16, 32'h0, 0, got);
        check("t2b_rx1", got, 32'hBBBB);
        xfer(1, 16, 32'h0, 0, got);
        check("t2b_rx2", got, 32'hFFFF);
        set_ss(1, 1'b1);
        check("t2b_tx_udf", tx_udf_b, 1);
        check("t2b_busy_end", busy_b, 0);
        sclk = 1'b0;
        clks(4);

        // 3: RX overflow on the fifth word, then err_clr
        words_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        set_ss(0, 1'b0);
        for (int k = 0; k < 5; k++) xfer(0, 8, {24'h0, words_a[k]}, 0, got);
        set_ss(0, 1'b1);
        check("t3_rx_ovf", rx_ovf_a, 1);
        check("t3_tx_udf", tx_udf_a, 1);
        pulse_err_clr(0);
        check("t3_ovf_clr", rx_ovf_a, 0);
        check("t3_udf_clr", tx_udf_a, 0);
        for (int k = 0; k < 4; k++) pop_a($sformatf("t3_rx_word%0d", k), words_a[k]);
        check("t3_rx_empty", rx_valid_a, 0);

        // 4: pop on the exact cycle a word is pushed into a full FIFO
        set_ss(0, 1'b0);
        for (int k = 1; k <= 4; k++) xfer(0, 8, k, 0, got);
        xfer(0, 8, 32'h05, 1, got);
        set_ss(0, 1'b1);
        check("t4_rx_ovf", rx_ovf_a, 0);
        for (int k = 2; k <= 5; k++) pop_a($sformatf("t4_rx_word%0d", k), 8'(k));
        check("t4_rx_empty", rx_valid_a, 0);

        // 5: aborted partial word is discarded
        set_ss(0, 1'b0);
        xfer(0, 5, 32'hE7, 0, got);
        set_ss(0, 1'b1);
        check("t5_no_partial", rx_valid_a, 0);
        set_ss(0, 1'b0);
        xfer(0, 8, 32'h5A, 0, got);
        set_ss(0, 1'b1);
        pop_a("t5_rx_data", 8'h5A);
        check("t5_rx_empty", rx_valid_a, 0);

        // 6: reset mid-word with two words queued
        pulse_err_clr(0);
        set_ss(0, 1'b0);
        xfer(0, 8, 32'h81, 0, got);
        xfer(0, 8, 32'h42, 0, got);
        check("t6_queued", rx_valid_a, 1);
        check("t6_udf_before", tx_udf_a, 1);
        xfer(0, 3, 32'hFF, 0, got);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        clks(2);
        check("t6_rx_valid", rx_valid_a, 0);
        check("t6_rx_ovf", rx_ovf_a, 0);
        check("t6_tx_udf", tx_udf_a, 0);
        check("t6_miso_oe", miso_oe_a, 0);
        xfer(0, 8, 32'h99, 0, got);
        xfer(0, 8, 32'h77, 0, got);
        check("t6_ignored", rx_valid_a, 0);
        check("t6_still_idle", busy_a, 0);
        set_ss(0, 1'b1);
        set_ss(0, 1'b0);
        xfer(0, 8, 32'h66, 0, got);
        set_ss(0, 1'b1);
        pop_a("t6_recover", 8'h66);
        check("t6_rx_empty", rx_valid_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_fifo.md
Name: spi_slave_fifo

Overview:
Parametrised full-duplex SPI slave, successor to the byte-only receive-only SPI slave. Supports all four CPOL/CPHA modes, configurable word width and independent RX/TX FIFO depths. Adds MISO transmit, sticky overflow/underflow flags and continuous multi-word frames. All SPI pins are oversampled in the system clock domain, so there is no separate sclk clock domain. Sits on the SoC peripheral bus as a strobe-driven data port.

Parameters:
WIDTH, 8, bits per SPI word (4..32)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
TX_IDLE, all-ones, word shifted out when the TX FIFO is empty

Ports:
clk  in  1  system clock; must be >= 4x sclk frequency
resetn  in  1  synchronous, active-low reset
rx_data  out  WIDTH  head of RX FIFO (valid when rx_valid=1)
rx_valid  out  1  RX FIFO non-empty
rx_rd  in  1  pop strobe; ignored when empty
tx_data  in  WIDTH  word to transmit
tx_wr  in  1  push strobe; ignored when tx_full
tx_full  out  1  TX FIFO full
rx_ovf  out  1  sticky: received word dropped because RX FIFO full
tx_udf  out  1  sticky: TX_IDLE sent because TX FIFO empty
err_clr  in  1  clears rx_ovf and tx_udf
busy  out  1  synchronised ss asserted
ss  in  1  slave select, active low, asynchronous
sclk  in  1  SPI clock, asynchronous
mosi  in  1  SPI data in, asynchronous
miso  out  1  SPI data out
miso_oe  out  1  tristate enable; 1 while busy

Behaviour:
- Decided: one clock; reset is synchronous and active-low (clk, resetn).
- ss, sclk and mosi each pass through a 2-FF synchroniser. A third sclk stage provides edge detection. Edge-to-action latency is 3 clk.
- Leading edge = sclk leaving the CPOL level; trailing edge = returning to it.
- FSM states:
  - IDLE: ss high. On synchronised ss fall: load the TX shift register, clear the bit counter, go to SHIFT.
  - SHIFT: on each sample edge, shift mosi into the RX shifter and increment the bit counter. On each shift edge, advance the TX shifter.
    - CPHA=0: the first TX bit is presented at load.
    - CPHA=1: the first TX bit is presented at the first leading edge.
  - On any synchronised ss rise: go to IDLE, discard the partial RX word and the loaded TX word, clear the bit counter. Nothing is pushed.
- Word complete (counter reaches WIDTH-1 on a sample edge):
  - One clk later, push the assembled word into the RX FIFO.
  - Reload the TX shifter for the next word without leaving SHIFT (back-to-back words).
  - If the RX FIFO is full and rx_rd is not asserted that cycle, drop the word and set rx_ovf.
  - If rx_rd is asserted on the same cycle as a push into a full FIFO, both occur and no overflow is flagged.
- TX load: pop the TX FIFO head. If the FIFO is empty, load TX_IDLE and set tx_udf.
- Bit order: MSB first on both lines.
- miso = TX shifter MSB; it is 0 while IDLE.
- Flags:
  - If err_clr and a set event coincide, the set wins.
  - rx_valid, tx_full and busy are combinational from registered state.
- Reset mid-frame: FSM returns to IDLE, both FIFOs are empty, flags clear, and the remainder of the current frame is ignored until ss rises and falls again.
- Reset values: rx_data 0, rx_valid 0, tx_full 0, rx_ovf 0, tx_udf 0, busy 0, miso 0, miso_oe 0.
- FIFO pointers are $clog2(DEPTH) bits wide and wrap naturally. Fill counters are $clog2(DEPTH)+1 bits, so all DEPTH entries are usable (no one-slot loss).

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN:
- Defined: both shifters operate LSB first, and miso = TX shifter LSB.
- Undefined: MSB first as specified above.
- FIFO contents and word alignment are identical in both cases.

Decomposition:
- Package spi_slave_pkg: FSM state enum (IDLE, SHIFT); CPOL/CPHA mode constants (MODE0..MODE3); synchroniser stage count (2).
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push/pop/full/empty/count), instantiated twice for RX and TX.

Test Plan:
1. Mode 0, WIDTH=8, tx_data 0x3C preloaded; master sends 0xA5 → rx_data=0xA5, rx_valid=1, master receives 0x3C, tx_udf=0.
2. Mode 3, WIDTH=16; three back-to-back words 0x1234/0xBEEF/0x0001 in one ss frame → RX FIFO holds all three in order; TX FIFO empty → master receives 0xFFFF x3, tx_udf=1.
3. RX_DEPTH=4; send 5 words with no rx_rd → first 4 retained, rx_ovf=1; err_clr → rx_ovf=0.
4. FIFO full and rx_rd pulsed on the exact push cycle → pop and push both occur, rx_ovf stays 0, count stays 4.
5. ss raised after 5 bits of a word, then a full word 0x5A sent → only 0x5A pushed, no partial word.
6. resetn low for one clk mid-word with 2 words queued → rx_valid=0, flags 0, miso_oe=0; bytes in the remainder of that frame are not captured.
